// File: rtl/ccff_multi_loader.sv
// Streams a bitstream into NUM_CHAINS parallel ccff chains, one bit per chain per accepted word.
// Latency: ccff_head/chain_en update 1 cycle after handshake or state entry; done 1 cycle after the last word.
// Backpressure: in_ready only in LOAD (dropped by abort); a cycle without handshake freezes the chains.
// Optional: define CCFF_TAIL_CHECK_EN for flush + marker injection and per-chain tail verification.
module ccff_multi_loader #(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 7424,
  parameter int CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_CHAINS-1:0] in_data,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  chain_en,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [NUM_CHAINS-1:0] err_chain
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_MARKER = 3'd2,
    ST_LOAD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Counter compare points: last word/flush cycle, and the word whose shift lands the marker on the tail.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CHAIN_LEN - 2);

`ifdef CCFF_TAIL_CHECK_EN
  localparam state_t ST_FIRST = ST_FLUSH;
`else
  localparam state_t ST_FIRST = ST_LOAD;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CHAINS-1:0]   head_d;
  logic                    en_d;
  logic                    done_d;
  logic                    clr_err;
`ifdef CCFF_TAIL_CHECK_EN
  logic                    chk_d, exp_d;
`endif

  assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // Next-state, counter and registered-output decode; abort overrides everything else.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    head_d   = ccff_head;
    en_d     = 1'b0;
    done_d   = done;
    clr_err  = 1'b0;
    in_ready = 1'b0;
`ifdef CCFF_TAIL_CHECK_EN
    chk_d    = 1'b0;
    exp_d    = 1'b0;
`endif
    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      head_d  = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          head_d = '0;
          if (start) begin
            clr_err = 1'b1;
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_FIRST;
          end
        end
`ifdef CCFF_TAIL_CHECK_EN
        ST_FLUSH: begin
          head_d = '0;
          en_d   = 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Only the final flush shift is checked: earlier tails still show stale contents.
            chk_d   = 1'b1;
            exp_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_MARKER;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_MARKER: begin
          head_d  = '1;
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
`endif
        ST_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            head_d = in_data;
            en_d   = 1'b1;
`ifdef CCFF_TAIL_CHECK_EN
            // Data shift cnt+1: marker must reach the tail on shift CHAIN_LEN-1; the last shift is unchecked.
            chk_d  = (cnt_q != CNT_LAST);
            exp_d  = (cnt_q == CNT_PRE);
`endif
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            clr_err = 1'b1;
            done_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_FIRST;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          head_d  = '0;
        end
      endcase
    end
  end

  // State register plus registered chain drive, so head and enable always move together.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ccff_head <= '0;
      chain_en  <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ccff_head <= head_d;
      chain_en  <= en_d;
      done      <= done_d;
    end
  end

`ifdef CCFF_TAIL_CHECK_EN
  logic chk_q, exp_q;
  logic shift_d, chk_s, exp_s;

  // Carry the expected-tail tag alongside chain_en, then one more cycle to meet the settled tail.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      chk_q     <= 1'b0;
      exp_q     <= 1'b0;
      shift_d   <= 1'b0;
      chk_s     <= 1'b0;
      exp_s     <= 1'b0;
      err_chain <= '0;
    end else begin
      chk_q   <= chk_d;
      exp_q   <= exp_d;
      shift_d <= chain_en;
      chk_s   <= chk_q;
      exp_s   <= exp_q;
      // A new load clears the flags and drops any compare still pending from the previous one.
      if (clr_err)
        err_chain <= '0;
      else if (shift_d && chk_s)
        err_chain <= err_chain | (ccff_tail ^ {NUM_CHAINS{exp_s}});
    end
  end

  assign err = |err_chain;
`else
  logic unused_sig;
  assign unused_sig = ^{ccff_tail, clr_err};
  assign err_chain  = '0;
  assign err        = 1'b0;
`endif

endmodule
